// File: rtl/fgen_pkg.sv
// Shared encodings for the function-generator waveform controller.
// Waveform codes, controller states and the default drain limit.
package fgen_pkg;

  typedef enum logic [1:0] {
    WAVE_SQUARE   = 2'd0,
    WAVE_TRIANGLE = 2'd1,
    WAVE_SAW      = 2'd2,
    WAVE_SINE     = 2'd3
  } wave_e;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_RESTART = 2'd2
  } state_e;

  localparam int DRAIN_MAX_DEF = 255;

endpackage

// File: rtl/wave_gen_controller_tick_divider.sv
// Programmable sample-tick divider with saturating up/down divide value.
// gen_en pulses every div_val+1 clocks; clr restarts the count silently.
module tick_divider #(
  parameter int DIV_W       = 16,
  parameter int DIV_DEFAULT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic freq_up,
  input  logic freq_down,
  input  logic clr,
  output logic gen_en
);

  logic [DIV_W-1:0] div_val_q, div_val_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             gen_en_q, gen_en_d;

  always_comb begin
    div_val_d = div_val_q;
    if (freq_up && !freq_down && div_val_q != '0)
      div_val_d = div_val_q - 1'b1;
    else if (freq_down && !freq_up && div_val_q != '1)
      div_val_d = div_val_q + 1'b1;
  end

  // >= lets a freshly lowered divide value wrap on the next cycle
  always_comb begin
    gen_en_d  = 1'b0;
    div_cnt_d = div_cnt_q + 1'b1;
    if (clr) begin
      div_cnt_d = '0;
    end else if (div_cnt_q >= div_val_q) begin
      gen_en_d  = 1'b1;
      div_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_val_q <= DIV_W'(DIV_DEFAULT);
      div_cnt_q <= '0;
      gen_en_q  <= 1'b0;
    end else begin
      div_val_q <= div_val_d;
      div_cnt_q <= div_cnt_d;
      gen_en_q  <= gen_en_d;
    end
  end

  assign gen_en = gen_en_q;

endmodule

// File: rtl/wave_gen_controller.sv
// Waveform sequencer: tick generation, glitch-free generator switching
// (drain to zero, restart pulse) and scaled sample output to the DAC.
module wave_gen_controller
  import fgen_pkg::*;
#(
  parameter int DIV_W       = 16,
  parameter int DIV_DEFAULT = 1,
  parameter int WAVE_W      = 8,
  parameter int DRAIN_MAX   = DRAIN_MAX_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sel_valid,
  output logic                sel_ready,
  input  logic [1:0]          sel_req,
  input  logic                freq_up,
  input  logic                freq_down,
  input  logic [1:0]          amp_shift,
  input  logic [4*WAVE_W-1:0] wave_in,
  output logic                gen_en,
  output logic                gen_rst,
  output logic [WAVE_W-1:0]   wave_out,
  output logic [1:0]          active_sel,
  output logic                busy
);

  localparam int DC_W = $clog2(DRAIN_MAX + 1);

  state_e            state_q, state_d;
  logic [1:0]        active_q, active_d;
  logic [1:0]        pending_q, pending_d;
  logic [DC_W-1:0]   drain_cnt_q, drain_cnt_d;
  logic [WAVE_W-1:0] wave_q, wave_d;
  logic              gen_rst_q, gen_rst_d;

  logic [WAVE_W-1:0] act_smp;
  logic              drain_last;
  logic              go_restart;
  logic              div_clr;

  assign act_smp = wave_in[int'(active_q)*WAVE_W +: WAVE_W];

  // drain_cnt holds ticks already spent; this tick is number DRAIN_MAX
  assign drain_last = (drain_cnt_q == DC_W'(DRAIN_MAX - 1));
  assign go_restart = (state_q == ST_DRAIN) && gen_en &&
                      ((act_smp == '0) || drain_last);
  assign div_clr    = go_restart || (state_q == ST_RESTART);

  tick_divider #(
    .DIV_W      (DIV_W),
    .DIV_DEFAULT(DIV_DEFAULT)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .freq_up  (freq_up),
    .freq_down(freq_down),
    .clr      (div_clr),
    .gen_en   (gen_en)
  );

  always_comb begin
    state_d     = state_q;
    active_d    = active_q;
    pending_d   = pending_q;
    drain_cnt_d = drain_cnt_q;
    gen_rst_d   = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (sel_valid && sel_req != active_q) begin
          pending_d   = sel_req;
          drain_cnt_d = '0;
          state_d     = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (go_restart) begin
          state_d   = ST_RESTART;
          gen_rst_d = 1'b1;
        end else if (gen_en) begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end
      ST_RESTART: begin
        active_d = pending_q;
        state_d  = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    wave_d = act_smp >> amp_shift;
    if (state_q == ST_RESTART)
      wave_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      active_q    <= 2'd0;
      pending_q   <= 2'd0;
      drain_cnt_q <= '0;
      wave_q      <= '0;
      gen_rst_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      active_q    <= active_d;
      pending_q   <= pending_d;
      drain_cnt_q <= drain_cnt_d;
      wave_q      <= wave_d;
      gen_rst_q   <= gen_rst_d;
    end
  end

  assign sel_ready  = (state_q == ST_RUN);
  assign busy       = (state_q != ST_RUN);
  assign gen_rst    = gen_rst_q;
  assign wave_out   = wave_q;
  assign active_sel = active_q;

endmodule

// File: tb/tb_wave_gen_controller.sv
// Scoreboard bench for wave_gen_controller: a behavioural model queues
// expected outputs every clock, a monitor pops and compares them.
module tb_wave_gen_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel_valid = 1'b0;
  logic [1:0]  sel_req = 2'd0;
  logic        freq_up = 1'b0;
  logic        freq_down = 1'b0;
  logic [1:0]  amp_shift = 2'd0;
  logic [31:0] wave_in = '0;
  logic        sel_ready, gen_en, gen_rst, busy;
  logic [7:0]  wave_out;
  logic [1:0]  active_sel;

  int n_chk = 0;
  int n_pass = 0;

  wave_gen_controller dut (
    .clk       (clk),
    .rst       (rst),
    .sel_valid (sel_valid),
    .sel_ready (sel_ready),
    .sel_req   (sel_req),
    .freq_up   (freq_up),
    .freq_down (freq_down),
    .amp_shift (amp_shift),
    .wave_in   (wave_in),
    .gen_en    (gen_en),
    .gen_rst   (gen_rst),
    .wave_out  (wave_out),
    .active_sel(active_sel),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint got, input longint want);
    n_chk++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d, want %0d (t=%0t)", name, got, want, $time);
  endtask

  typedef struct packed {
    logic       en;
    logic       rs;
    logic [7:0] wo;
    logic [1:0] as;
    logic       bz;
    logic       rdy;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: mode 0 = running, 1 = draining, 2 = restarting.
  int m_dv = 1, m_ph = 0, m_tick = 0, m_mode = 0;
  int m_act = 0, m_pend = 0, m_spent = 0, m_wo = 0;

  always @(posedge clk) begin : model
    int smp, n_ph, n_tick, n_dv, n_mode, n_act, n_spent, n_wo;
    bit leave;
    if (rst) begin
      m_dv = 1; m_ph = 0; m_tick = 0; m_mode = 0;
      m_act = 0; m_pend = 0; m_spent = 0; m_wo = 0;
    end else begin
      smp    = int'(wave_in[m_act*8 +: 8]);
      leave  = (m_mode == 1) && (m_tick == 1) && (smp == 0 || m_spent + 1 == 255);
      n_dv   = m_dv;
      if (freq_up && !freq_down) n_dv = (m_dv > 0) ? m_dv - 1 : 0;
      if (freq_down && !freq_up) n_dv = (m_dv < 65535) ? m_dv + 1 : 65535;
      if (leave || m_mode == 2) begin
        n_tick = 0; n_ph = 0;
      end else if (m_ph >= m_dv) begin
        n_tick = 1; n_ph = 0;
      end else begin
        n_tick = 0; n_ph = m_ph + 1;
      end
      n_wo    = (m_mode == 2) ? 0 : (smp >> amp_shift);
      n_mode  = m_mode;
      n_act   = m_act;
      n_spent = m_spent;
      if (m_mode == 0 && sel_valid && int'(sel_req) != m_act) begin
        m_pend = int'(sel_req); n_spent = 0; n_mode = 1;
      end else if (m_mode == 1) begin
        if (leave) n_mode = 2;
        else if (m_tick == 1) n_spent = m_spent + 1;
      end else if (m_mode == 2) begin
        n_act = m_pend; n_mode = 0;
      end
      m_dv = n_dv; m_ph = n_ph; m_tick = n_tick; m_mode = n_mode;
      m_act = n_act; m_spent = n_spent; m_wo = n_wo;
    end
    exp_q.push_back('{en: 1'(m_tick), rs: (m_mode == 2), wo: 8'(m_wo),
                      as: 2'(m_act), bz: (m_mode != 0), rdy: (m_mode == 0)});
  end

  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("sb_gen_en", gen_en, e.en);
      chk("sb_gen_rst", gen_rst, e.rs);
      chk("sb_wave_out", wave_out, e.wo);
      chk("sb_active_sel", active_sel, e.as);
      chk("sb_busy", busy, e.bz);
      chk("sb_sel_ready", sel_ready, e.rdy);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic request(input logic [1:0] c);
    sel_valid = 1'b1;
    sel_req   = c;
    for (int i = 0; i < 2000; i++) begin
      if (sel_ready) begin
        @(negedge clk);
        sel_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    sel_valid = 1'b0;
    chk("req_timeout", 1, 0);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 1000; i++) begin
      if (!busy) return;
      @(negedge clk);
    end
    chk("idle_timeout", 1, 0);
  endtask

  task automatic measure(output int p);
    int k;
    p = -1;
    k = 0;
    while (!gen_en && k < 1000) begin
      @(negedge clk); k++;
    end
    if (k >= 1000) return;
    p = 0;
    do begin
      @(negedge clk); p++;
    end while (!gen_en && p < 1000);
  endtask

  initial begin
    int cnt, per, ticks;
    bit seen;
    cyc(3);
    rst = 1'b0;

    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      cnt += int'(gen_en);
    end
    chk("idle_ticks", cnt, 10);
    chk("idle_wave_out", wave_out, 0);
    chk("idle_active", active_sel, 0);
    chk("idle_ready", sel_ready, 1);

    freq_down = 1'b1; cyc(3); freq_down = 1'b0;
    cyc(12);
    measure(per);
    chk("period_div4", per, 5);

    freq_up = 1'b1; cyc(10); freq_up = 1'b0;
    cyc(2);
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      cnt += int'(gen_en);
    end
    chk("div0_const_en", cnt, 8);

    freq_down = 1'b1; cyc(1);
    freq_up = 1'b1; cyc(8);
    freq_up = 1'b0; freq_down = 1'b0;
    cyc(4);
    measure(per);
    chk("period_both_held", per, 2);

    wave_in = '0;
    request(2'd1);
    wait_idle();
    chk("sel_triangle", active_sel, 1);

    amp_shift = 2'd1;
    wave_in = {8'd7, 8'd100, 8'd40, 8'd9};
    request(2'd2);
    cyc(3);
    chk("drain_busy", busy, 1);
    chk("drain_ready", sel_ready, 0);
    chk("drain_wave", wave_out, 20);
    wave_in[15:8] = 8'd0;
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = gen_rst;
    end
    chk("restart_seen", seen, 1);
    @(negedge clk);
    chk("restart_1cyc", gen_rst, 0);
    chk("switched_saw", active_sel, 2);
    chk("restart_zero", wave_out, 0);
    @(negedge clk);
    chk("saw_scaled", wave_out, 50);

    freq_up = 1'b1; cyc(2); freq_up = 1'b0;
    wave_in = {8'd3, 8'd5, 8'd6, 8'd9};
    request(2'd3);
    ticks = 0;
    seen = 0;
    for (int i = 0; i < 600 && !seen; i++) begin
      if (gen_rst) seen = 1;
      else begin
        if (busy && gen_en) ticks++;
        @(negedge clk);
      end
    end
    chk("forced_seen", seen, 1);
    chk("forced_ticks", ticks, 255);
    wait_idle();
    chk("forced_sine", active_sel, 3);

    freq_down = 1'b1; cyc(1); freq_down = 1'b0;
    request(2'd0);
    cyc(3);
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("rst_gen_en", gen_en, 0);
    chk("rst_gen_rst", gen_rst, 0);
    chk("rst_wave_out", wave_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_active", active_sel, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", sel_ready, 1);
    chk("post_rst_active", active_sel, 0);

    request(2'd0);
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      cnt += int'(busy) + int'(gen_rst);
    end
    chk("same_sel_noop", cnt, 0);

    for (int i = 0; i < 500; i++) begin
      for (int b = 0; b < 4; b++)
        wave_in[b*8 +: 8] = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
      amp_shift = 2'($urandom);
      freq_up   = ($urandom_range(0, 7) == 0);
      freq_down = ($urandom_range(0, 7) == 0);
      sel_valid = ($urandom_range(0, 5) == 0);
      sel_req   = 2'($urandom);
      @(negedge clk);
    end
    sel_valid = 1'b0;
    freq_up = 1'b0;
    freq_down = 1'b0;
    cyc(3);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
